gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
Parameterised up-counter that keeps a binary count and a registered Gray-coded copy of it. It is the encode-side companion of the Gray-to-binary decoder: the Gray output feeds a clock-domain crossing (for example an async FIFO pointer), and the far side decodes it back to binary. The Gray output is taken directly from a flop, so exactly one bit changes per increment and the output never glitches.

Parameters:
- WIDTH, 4, counter and Gray word width in bits; legal range is 2 to 32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear to zero; highest priority.
- load  input  1  synchronous load of load_value; second priority.
- load_value  input  WIDTH  binary value captured when load=1.
- inc  input  1  increment by 1 when neither clr nor load is asserted.
- bin_count  output  WIDTH  registered binary count.
- gray_count  output  WIDTH  registered Gray code of bin_count.
- wrap  output  1  registered one-cycle pulse when the count wraps from all-ones to zero.

Behaviour:
- Reset: the block has one clock (clk). Reset rst_n is asynchronous and active-low. While rst_n=0: bin_count=0, gray_count=0, wrap=0, regardless of clk. Deassertion takes effect at the next rising edge.
- Next-state priority, per cycle: clr > load > inc > hold.
  - clr=1: bin_next=0.
  - load=1: bin_next=load_value.
  - inc=1: bin_next=(bin_count+1) mod 2^WIDTH.
  - Otherwise: bin_next=bin_count.
- Gray encoding: gray_next = bin_next XOR (bin_next >> 1). The MSB passes through unchanged; bit i = bin[i+1] XOR bin[i].
- gray_count is registered from gray_next in the same edge as bin_count. No combinational path from any input to any output.
- Latency: one cycle from a qualifying input to both outputs. The two outputs are always mutually consistent: gray_count == bin2gray(bin_count) on every cycle.
- wrap=1 in the cycle after an edge where inc was accepted with bin_count == all-ones, i.e. no clr or load that cycle. Otherwise wrap=0.
  - A load of zero never asserts wrap.
  - A clr never asserts wrap.
- Simultaneous events:
  - clr with load and/or inc: clr wins, wrap=0.
  - load with inc: load wins; load_value is not incremented.
- Single-bit-change guarantee: for an accepted inc (including the wrap), the Hamming distance between old and new gray_count is exactly 1. clr and load are not bound by this guarantee; the consuming domain must treat them as a resynchronisation event.
- Reset mid-operation: asserting rst_n=0 at any time forces all outputs to 0 immediately. The pending inc, load or clr is discarded.

Decomposition:
- Shared package: GRAY_CNT_DEFAULT_WIDTH = 4. No typedefs are needed.
- One combinational sub-module, binary_gray: input bin[WIDTH], output gray[WIDTH], pure XOR/buf structure. It is the counterpart of the existing decoder and can be reused standalone.
- gray_counter instantiates binary_gray on bin_next and registers its output.

Test Plan:
- Reset: hold rst_n=0 with inc=1 for 3 clocks. Required: bin_count=0, gray_count=0, wrap=0 throughout.
- Full sweep, WIDTH=4, inc=1 for 16 cycles from reset. Required gray_count sequence: 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8. Each step changes exactly one bit. wrap pulses once, after 15->0, with gray returning from 8 to 0.
- Load: load=1, load_value=4'hA, inc=1 in the same cycle. Required next cycle: bin_count=A, gray_count=F, wrap=0. After one further inc: bin_count=B, gray_count=E.
- Clear priority: clr=1, load=1 with load_value=4'h5, inc=1, bin_count=F. Required: bin_count=0, gray_count=0, wrap=0.
- Hold and async reset: inc=0 for 4 cycles at bin_count=6, gray_count=5. Values must hold. Then drop rst_n between clock edges. Outputs must go to 0 before the next rising edge.
- Self-check across all WIDTH=4 values: a scoreboard decodes gray_count with the existing Gray-to-binary decoder. The decoded value must equal bin_count on every cycle.

Source files
------------

// File: rtl/gray_counter_pkg.sv
// Shared constants for the Gray-coded pointer counter.
package gray_counter_pkg;

   localparam int GRAY_CNT_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/binary_gray.sv
// Binary-to-Gray encoder; pure XOR network, the mirror of the Gray decoder.
module binary_gray #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up-counter with a flop-sourced Gray copy for clock-domain crossing.
module gray_counter
   import gray_counter_pkg::*;
#(
   parameter int WIDTH = GRAY_CNT_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             inc,
   output logic [WIDTH-1:0] bin_count,
   output logic [WIDTH-1:0] gray_count,
   output logic             wrap
);

   logic [WIDTH-1:0] bin_d, bin_q;
   logic [WIDTH-1:0] gray_d, gray_q;
   logic             wrap_d, wrap_q;

   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      priority case (1'b1)
         clr:  bin_d = '0;
         load: bin_d = load_value;
         inc: begin
            bin_d  = bin_q + WIDTH'(1);
            wrap_d = &bin_q;
         end
         default: bin_d = bin_q;
      endcase
   end

   // Encode the next value so the Gray word is registered, never derived.
   binary_gray #(
      .WIDTH(WIDTH)
   ) u_enc (
      .bin (bin_d),
      .gray(gray_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bin_count  = bin_q;
   assign gray_count = gray_q;
   assign wrap       = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Randomised bench for gray_counter against an arithmetic reference model.
module tb_gray_counter;

   localparam int W = 4;
   localparam int M = 1 << W;

   logic         clk;
   logic         rst_n;
   logic         clr;
   logic         load;
   logic [W-1:0] load_value;
   logic         inc;
   logic [W-1:0] bin_count;
   logic [W-1:0] gray_count;
   logic         wrap;

   int n_chk;
   int n_err;
   int m_bin;
   bit m_wrap;
   int nw;

   logic [3:0] tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   gray_counter #(
      .WIDTH(W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .load      (load),
      .load_value(load_value),
      .inc       (inc),
      .bin_count (bin_count),
      .gray_count(gray_count),
      .wrap      (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int b2g(input int b);
      return b ^ (b / 2);
   endfunction

   // Reference Gray-to-binary decoder: running XOR from the MSB down.
   function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
      logic [W-1:0] b;
      b[W-1] = g[W-1];
      for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit c, input bit l, input int lv, input bit i);
      int old;
      old        = m_bin;
      clr        = c;
      load       = l;
      load_value = W'(lv);
      inc        = i;
      @(posedge clk);
      m_wrap = 1'b0;
      if (c) m_bin = 0;
      else if (l) m_bin = lv % M;
      else if (i) begin
         m_wrap = (m_bin == M - 1);
         m_bin  = (m_bin + 1) % M;
      end
      #1;
      chk("bin", int'(bin_count), m_bin);
      chk("gray", int'(gray_count), b2g(m_bin));
      chk("wrap", int'(wrap), int'(m_wrap));
      chk("decode", int'(g2b(gray_count)), int'(bin_count));
      if (!c && !l && i)
         chk("onebit", $countones(gray_count ^ W'(b2g(old))), 1);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      m_bin = 0;
      m_wrap = 1'b0;
      rst_n = 1'b0;
      clr = 1'b0;
      load = 1'b0;
      load_value = '0;
      inc = 1'b1;

      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("rst_bin", int'(bin_count), 0);
         chk("rst_gray", int'(gray_count), 0);
         chk("rst_wrap", int'(wrap), 0);
      end
      rst_n = 1'b1;

      nw = 0;
      for (int k = 0; k < 16; k++) begin
         step(0, 0, 0, 1);
         chk("sweep", int'(gray_count), int'(tab[(k + 1) % 16]));
         if (wrap) nw++;
      end
      chk("wrap_cnt", nw, 1);

      step(0, 1, 'hA, 1);
      chk("ld_bin", int'(bin_count), 'hA);
      chk("ld_gray", int'(gray_count), 'hF);
      step(0, 0, 0, 1);
      chk("ld_inc_gray", int'(gray_count), 'hE);

      step(0, 1, 'hF, 0);
      step(1, 1, 'h5, 1);
      chk("clr_bin", int'(bin_count), 0);
      chk("clr_wrap", int'(wrap), 0);

      step(0, 1, 0, 0);
      chk("ld0_wrap", int'(wrap), 0);

      step(0, 1, 6, 0);
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 0);
         chk("hold_gray", int'(gray_count), 5);
      end
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_bin", int'(bin_count), 0);
      chk("async_gray", int'(gray_count), 0);
      chk("async_wrap", int'(wrap), 0);
      #2;
      rst_n = 1'b1;
      m_bin = 0;

      for (int k = 0; k < 400; k++) begin
         int r;
         r = int'($urandom_range(0, 99));
         step(r < 4, (r >= 4) && (r < 12), int'($urandom_range(0, M - 1)),
              $urandom_range(0, 9) < 8);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
